// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the memory stage and its lane aligner.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and alignment/extension for loads.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    input  logic [31:0] data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rdata[{a, 3'b000} +: 8];
    assign w_half = a[1] ? rdata[31:16] : rdata[15:0];

    // Any funct3 outside the byte/half encodings falls through to the word case.
    always_comb begin
        be         = 4'b1111;
        wdata      = data;
        load_val   = rdata;
        misaligned = (a != 2'b00);
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << a;
                wdata      = {4{data[7:0]}};
                load_val   = (funct3 == F3_BU) ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                misaligned = 1'b0;
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << {a[1], 1'b0};
                wdata      = {2{data[15:0]}};
                load_val   = (funct3 == F3_HU) ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                misaligned = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores on a req/gnt/rvalid bus and
// registers the writeback/forwarding value.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_ex,
    input  logic [31:0] result,
    input  logic [31:0] data,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] rdMem,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_t    r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_we, r_wb_valid, r_wb_we, r_misalign, r_bus_err;
    logic [2:0]    r_f3;
    logic [1:0]    r_a;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_addr, r_wdata, r_rdmem;
    logic [3:0]    r_be;

    logic          w_is_load, w_is_store, w_is_mem, w_accept, w_complete, w_timeout;
    logic [2:0]    w_f3;
    logic [1:0]    w_a;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_load_val;
    logic          w_misaligned;

    assign w_is_load  = (opcode == OPC_LOAD);
    assign w_is_store = (opcode == OPC_STORE);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_accept   = (r_state == IDLE) && ex_valid;

    // Aligner is shared: incoming op while IDLE, latched op during the bus transfer.
    // Stores have no unsigned widths, so BU/HU on a store are forced to word.
    assign w_f3 = (r_state != IDLE) ? r_f3 :
                  (w_is_store && funct3[2]) ? F3_W : funct3;
    assign w_a  = (r_state != IDLE) ? r_a : result[1:0];

    lsu_align u_align (
        .funct3     (w_f3),
        .a          (w_a),
        .data       (data),
        .rdata      (dmem_rdata),
        .be         (w_be),
        .wdata      (w_wdata),
        .load_val   (w_load_val),
        .misaligned (w_misaligned)
    );

    assign w_complete = ((r_state == REQ) && dmem_gnt && dmem_rvalid) ||
                        ((r_state == WAIT) && dmem_rvalid);
    assign w_timeout  = (r_state != IDLE) && !w_complete && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept && w_is_mem && !w_misaligned) w_next = REQ;
            REQ: begin
                if (w_complete || w_timeout) w_next = IDLE;
                else if (dmem_gnt)           w_next = WAIT;
            end
            WAIT: if (w_complete || w_timeout) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_f3       <= '0;
            r_a        <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_rdmem    <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_accept) begin
                r_wb_rd <= rd_ex;
                if (!w_is_mem) begin
                    r_wb_valid <= 1'b1;
                    r_wb_we    <= (rd_ex != 5'd0);
                    r_rdmem    <= result;
                end else if (w_misaligned) begin
                    r_wb_valid <= 1'b1;
                    r_misalign <= 1'b1;
                end else begin
                    r_we    <= w_is_store;
                    r_f3    <= w_f3;
                    r_a     <= result[1:0];
                    r_addr  <= {result[31:2], 2'b00};
                    r_wdata <= w_wdata;
                    r_be    <= w_be;
                    r_cnt   <= '0;
                end
            end else if (r_state != IDLE) begin
                if (w_complete) begin
                    r_wb_valid <= 1'b1;
                    if (!r_we) begin
                        r_wb_we <= (r_wb_rd != 5'd0);
                        r_rdmem <= w_load_val;
                    end
                end else if (w_timeout) begin
                    r_wb_valid <= 1'b1;
                    r_bus_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign mem_stall  = (r_state != IDLE);
    assign dmem_req   = (r_state == REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign wb_valid   = r_wb_valid;
    assign wb_we      = r_wb_we;
    assign wb_rd      = r_wb_rd;
    assign rdMem      = r_rdmem;
    assign misalign   = r_misalign;
    assign bus_err    = r_bus_err;

endmodule
